ddr2_init_engine: RTL

Power-up initialisation sequencer for the DDR2 controller. It drives the JEDEC DDR2 init command sequence (CKE hold-off, precharge-all, EMR2/EMR3/EMR1/MR loads, DLL reset, two auto-refreshes, OCD calibration default/exit, DLL lock wait) onto the `init_*` inputs of `ddr2_phy`. When the sequence completes it raises `ready`, which hands the command/address pads over to the protocol engine.

---
 rtl/ddr2_pkg.sv | 68 ++++++
 rtl/ddr2_wait_timer.sv | 24 ++
 rtl/ddr2_init_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ddr2_pkg.sv
// Shared types and constants for the DDR2 power-up initialisation sequencer.
package ddr2_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_CKE_LOW,
    ST_NOP_WAIT,
    ST_PRE1,
    ST_EMR2,
    ST_EMR3,
    ST_EMR1,
    ST_MR_DLLRST,
    ST_PRE2,
    ST_REF1,
    ST_REF2,
    ST_MR,
    ST_OCD_DEF,
    ST_OCD_EXIT,
    ST_WAIT,
    ST_DLL_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    WAIT_RP,
    WAIT_MRD,
    WAIT_RFC
  } wait_kind_t;

  // {csbar, rasbar, casbar, webar}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_DESEL = 4'b1111;
  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_REF   = 4'b0001;
  localparam cmd_t CMD_MRS   = 4'b0000;

  localparam logic [12:0] A8_DLL_RST   = 13'h0100;
  localparam logic [12:0] A9_7_OCD_DEF = 13'h0380;
  localparam logic [12:0] A10_PRE_ALL  = 13'h0400;

  // Command that follows the wait after command s; ST_DLL_WAIT marks the end of the list.
  function automatic state_t next_cmd_of(state_t s);
    case (s)
      ST_PRE1:      return ST_EMR2;
      ST_EMR2:      return ST_EMR3;
      ST_EMR3:      return ST_EMR1;
      ST_EMR1:      return ST_MR_DLLRST;
      ST_MR_DLLRST: return ST_PRE2;
      ST_PRE2:      return ST_REF1;
      ST_REF1:      return ST_REF2;
      ST_REF2:      return ST_MR;
      ST_MR:        return ST_OCD_DEF;
      ST_OCD_DEF:   return ST_OCD_EXIT;
      default:      return ST_DLL_WAIT;
    endcase
  endfunction

  function automatic wait_kind_t wait_kind_of(state_t s);
    case (s)
      ST_PRE1, ST_PRE2: return WAIT_RP;
      ST_REF1, ST_REF2: return WAIT_RFC;
      default:          return WAIT_MRD;
    endcase
  endfunction

endpackage

// File: rtl/ddr2_wait_timer.sv
// 16-bit loadable down-counter that saturates at zero; done flags a zero count.
module ddr2_wait_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign done = (count == 16'd0);

endmodule

// File: rtl/ddr2_init_engine.sv
// DDR2 power-up init sequencer: drives the JEDEC init command list, then raises ready.
//   state        | meaning
//   IDLE         | reset outputs, waiting for init
//   CKE_LOW      | DESELECT with cke low for T_CKE_LOW cycles
//   NOP_WAIT     | NOP with cke high for T_NOP cycles
//   PRE1..OCD_EXIT | one-cycle command from the init list
//   WAIT         | NOPs for tRP/tMRD/tRFC, then next_cmd
//   DLL_WAIT     | NOP until the DLL counter reaches zero
//   DONE         | ready=1, NOP, held until reset
module ddr2_init_engine
  import ddr2_pkg::*;
#(
  parameter int unsigned  T_CKE_LOW = 200,
  parameter int unsigned  T_NOP     = 80,
  parameter int unsigned  T_RP      = 3,
  parameter int unsigned  T_MRD     = 2,
  parameter int unsigned  T_RFC     = 26,
  parameter int unsigned  T_DLL     = 200,
  parameter logic [12:0]  MR_VAL    = 13'h0642,
  parameter logic [12:0]  EMR1_VAL  = 13'h0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  output logic        ready,
  output logic        csbar,
  output logic        rasbar,
  output logic        casbar,
  output logic        webar,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic [1:0]  dm,
  output logic        odt,
  output logic        cke
);

  state_t      state, state_nxt, next_cmd;
  logic        tmr_load, tmr_done, dll_load, dll_done;
  logic [15:0] tmr_val;
  cmd_t        cmd_nxt;
  logic [1:0]  ba_nxt;
  logic [12:0] a_nxt;

  function automatic logic [15:0] wait_len(state_t s);
    case (wait_kind_of(s))
      WAIT_RP:  return 16'(T_RP - 1);
      WAIT_RFC: return 16'(T_RFC - 1);
      default:  return 16'(T_MRD - 1);
    endcase
  endfunction

  // Timers are loaded with T-1 on the edge entering a timed state, so that state lasts T cycles.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    dll_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init) begin
          state_nxt = ST_CKE_LOW;
          tmr_load  = 1'b1;
          tmr_val   = 16'(T_CKE_LOW - 1);
        end
      end
      ST_CKE_LOW: begin
        if (tmr_done) begin
          state_nxt = ST_NOP_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = 16'(T_NOP - 1);
        end
      end
      ST_NOP_WAIT: begin
        if (tmr_done) state_nxt = ST_PRE1;
      end
      ST_WAIT: begin
        if (tmr_done) begin
          if (next_cmd == ST_DLL_WAIT) begin
            state_nxt = dll_done ? ST_DONE : ST_DLL_WAIT;
          end else begin
            state_nxt = next_cmd;
          end
          // DLL count covers the MR_DLLRST cycle itself, hence T_DLL-1.
          dll_load = (next_cmd == ST_MR_DLLRST);
        end
      end
      ST_DLL_WAIT: begin
        if (dll_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_WAIT;
        tmr_load  = 1'b1;
        tmr_val   = wait_len(state);
      end
    endcase
  end

  always_comb begin
    cmd_nxt = CMD_NOP;
    ba_nxt  = 2'd0;
    a_nxt   = 13'd0;
    case (state_nxt)
      ST_IDLE, ST_CKE_LOW: cmd_nxt = CMD_DESEL;
      ST_PRE1, ST_PRE2: begin
        cmd_nxt = CMD_PRE;
        a_nxt   = A10_PRE_ALL;
      end
      ST_REF1, ST_REF2: cmd_nxt = CMD_REF;
      ST_EMR2: begin
        cmd_nxt = CMD_MRS;
        ba_nxt  = 2'd2;
      end
      ST_EMR3: begin
        cmd_nxt = CMD_MRS;
        ba_nxt  = 2'd3;
      end
      ST_EMR1, ST_OCD_EXIT: begin
        cmd_nxt = CMD_MRS;
        ba_nxt  = 2'd1;
        a_nxt   = EMR1_VAL;
      end
      ST_OCD_DEF: begin
        cmd_nxt = CMD_MRS;
        ba_nxt  = 2'd1;
        a_nxt   = EMR1_VAL | A9_7_OCD_DEF;
      end
      ST_MR_DLLRST: begin
        cmd_nxt = CMD_MRS;
        a_nxt   = MR_VAL | A8_DLL_RST;
      end
      ST_MR: begin
        cmd_nxt = CMD_MRS;
        a_nxt   = MR_VAL;
      end
      default: cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      next_cmd <= ST_PRE1;
      ready    <= 1'b0;
      cke      <= 1'b0;
      {csbar, rasbar, casbar, webar} <= CMD_DESEL;
      ba       <= 2'd0;
      a        <= 13'd0;
      dm       <= 2'd0;
      odt      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != ST_WAIT && state_nxt == ST_WAIT) next_cmd <= next_cmd_of(state);
      ready <= (state_nxt == ST_DONE);
      cke   <= !(state_nxt inside {ST_IDLE, ST_CKE_LOW});
      {csbar, rasbar, casbar, webar} <= cmd_nxt;
      ba    <= ba_nxt;
      a     <= a_nxt;
      dm    <= 2'd0;
      odt   <= 1'b0;
    end
  end

  ddr2_wait_timer u_seq_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  ddr2_wait_timer u_dll_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (dll_load),
    .load_val (16'(T_DLL - 1)),
    .done     (dll_done)
  );

endmodule
